// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// ahb3lite_interconnect_slave_arbiter
// Per-slave-port arbiter for the AHB3-Lite multi-layer interconnect.
// Picks one owner among the master ports requesting this slave and returns a
// registered one-hot grant. It also returns the address-phase and data-phase
// master indices that drive the slave-port multiplexers.
// Ownership only moves when the slave is ready and the current owner has either
// stopped requesting or declared the transfer boundary safe (can_switch).
// Optional feature: define AHB3LITE_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking among equal-priority requesters. Otherwise the lowest requesting
// index wins a tie.

module ahb3lite_interconnect_slave_arbiter #(
  parameter  int MASTERS     = 3,
  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [MASTERS-1:0]             mst_HSEL,
  input  logic [MASTERS*MASTER_BITS-1:0] mst_priority,
  input  logic [MASTERS-1:0]             mst_can_switch,
  input  logic                           slv_HREADY,
  output logic [MASTERS-1:0]             master_granted,
  output logic [MASTER_BITS-1:0]         master_sel,
  output logic [MASTER_BITS-1:0]         data_master_sel
);

  generate
    if (MASTERS == 1) begin : g_single

      // A single master permanently owns the slave; there is nothing to arbitrate
      assign master_granted  = 1'b1;
      assign master_sel      = '0;
      assign data_master_sel = '0;

    end else begin : g_multi

      localparam logic [MASTERS-1:0] GRANT_M0 = {{(MASTERS-1){1'b0}}, 1'b1};

      logic [MASTER_BITS-1:0] owner_q;
      logic [MASTER_BITS-1:0] data_owner_q;
      logic [MASTERS-1:0]     grant_q;
      logic [MASTER_BITS-1:0] winner;
      logic [MASTER_BITS-1:0] best_prio;
      logic [MASTER_BITS-1:0] cand_prio;
      logic [MASTER_BITS-1:0] idx;
      logic                   found;
      logic                   any_req;
      logic                   switch_ok;

`ifdef AHB3LITE_ARB_ROUND_ROBIN_EN
      logic [MASTER_BITS-1:0] rr_ptr_q;
`endif

      // Ownership may move only at a slave-accepted, owner-approved boundary
      always_comb begin
        switch_ok = slv_HREADY & (~mst_HSEL[owner_q] | mst_can_switch[owner_q]);
        any_req   = |mst_HSEL;
      end

      // Pick the highest-priority requester; the first one met in scan order keeps a tie
      always_comb begin
        winner    = owner_q;
        best_prio = '0;
        cand_prio = '0;
        idx       = '0;
        found     = 1'b0;
`ifdef AHB3LITE_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= MASTERS; k++) begin
          idx       = MASTER_BITS'((int'(rr_ptr_q) + k) % MASTERS);
          cand_prio = mst_priority[idx*MASTER_BITS +: MASTER_BITS];
          if (mst_HSEL[idx] && (!found || (cand_prio > best_prio))) begin
            found     = 1'b1;
            best_prio = cand_prio;
            winner    = idx;
          end
        end
`else
        for (int i = 0; i < MASTERS; i++) begin
          idx       = MASTER_BITS'(i);
          cand_prio = mst_priority[idx*MASTER_BITS +: MASTER_BITS];
          if (mst_HSEL[idx] && (!found || (cand_prio > best_prio))) begin
            found     = 1'b1;
            best_prio = cand_prio;
            winner    = idx;
          end
        end
`endif
      end

      // Register owner and grant at switch points; data-phase owner follows on HREADY
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          owner_q      <= '0;
          grant_q      <= GRANT_M0;
          data_owner_q <= '0;
        end else begin
          if (switch_ok && any_req) begin
            owner_q <= winner;
            grant_q <= GRANT_M0 << winner;
          end
          if (slv_HREADY) begin
            data_owner_q <= owner_q;
          end
        end
      end

`ifdef AHB3LITE_ARB_ROUND_ROBIN_EN
      // Remember the last winner so equal-priority ties rotate past it
      always_ff @(posedge HCLK) begin
        if (HRESET) begin
          rr_ptr_q <= '0;
        end else if (switch_ok && any_req) begin
          rr_ptr_q <= winner;
        end
      end
`endif

      assign master_granted  = grant_q;
      assign master_sel      = owner_q;
      assign data_master_sel = data_owner_q;

    end
  endgenerate

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// tb_ahb3lite_interconnect_slave_arbiter
// Directed bench for the per-slave AHB3-Lite arbiter with MASTERS=3.
// It covers reset, priority, locked-burst hold, wait states, parking,
// non-requester exclusion and equal-priority ties. The tie case expects a
// rotating grant when AHB3LITE_ARB_ROUND_ROBIN_EN is defined and a fixed
// lowest-index grant otherwise.

module tb_ahb3lite_interconnect_slave_arbiter;

  localparam int MASTERS     = 3;
  localparam int MASTER_BITS = 2;

  logic                           HCLK;
  logic                           HRESET;
  logic [MASTERS-1:0]             mst_HSEL;
  logic [MASTERS*MASTER_BITS-1:0] mst_priority;
  logic [MASTERS-1:0]             mst_can_switch;
  logic                           slv_HREADY;
  logic [MASTERS-1:0]             master_granted;
  logic [MASTER_BITS-1:0]         master_sel;
  logic [MASTER_BITS-1:0]         data_master_sel;

  int compared   = 0;
  int mismatched = 0;

  ahb3lite_interconnect_slave_arbiter #(.MASTERS(MASTERS)) dut (
    .HCLK            (HCLK),
    .HRESET          (HRESET),
    .mst_HSEL        (mst_HSEL),
    .mst_priority    (mst_priority),
    .mst_can_switch  (mst_can_switch),
    .slv_HREADY      (slv_HREADY),
    .master_granted  (master_granted),
    .master_sel      (master_sel),
    .data_master_sel (data_master_sel)
  );

  // Free-running clock, 10 time units per period
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one rising edge and settle away from it before looking at outputs
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Drive the arbiter inputs; priorities are given as {m2, m1, m0}
  task automatic applyStimulus(input logic [2:0] hsel, input logic [5:0] prio,
                               input logic [2:0] can_sw, input logic ready);
    mst_HSEL       = hsel;
    mst_priority   = prio;
    mst_can_switch = can_sw;
    slv_HREADY     = ready;
  endtask

  // Compare grant, address-phase select and data-phase select against expectations
  task automatic checkOutput(input string tag, input logic [2:0] exp_grant,
                             input logic [1:0] exp_sel, input logic [1:0] exp_dsel);
    compared++;
    assert (master_granted === exp_grant) else begin
      mismatched++;
      $error("[TB] FAIL %s grant: observed %b expected %b", tag, master_granted, exp_grant);
    end
    compared++;
    assert (master_sel === exp_sel) else begin
      mismatched++;
      $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, master_sel, exp_sel);
    end
    compared++;
    assert (data_master_sel === exp_dsel) else begin
      mismatched++;
      $error("[TB] FAIL %s data_sel: observed %0d expected %0d", tag, data_master_sel, exp_dsel);
    end
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    $display("[TB] starting arbiter bench");

    // Reset held two cycles while everyone requests
    HRESET = 1'b1;
    applyStimulus(3'b111, {2'd3, 2'd2, 2'd1}, 3'b111, 1'b1);
    tick();
    checkOutput("reset_c1", 3'b001, 2'd0, 2'd0);
    tick();
    checkOutput("reset_c2", 3'b001, 2'd0, 2'd0);
    HRESET = 1'b0;
    applyStimulus(3'b110, {2'd2, 2'd1, 2'd0}, 3'b111, 1'b1);
    checkOutput("reset_release", 3'b001, 2'd0, 2'd0);

    // Priority: m2 (2) beats m1 (1)
    tick();
    checkOutput("prio_switch", 3'b100, 2'd2, 2'd0);
    tick();
    checkOutput("prio_hold", 3'b100, 2'd2, 2'd2);

    // Locked burst: m0 owns and refuses to switch while m2 (prio 3) waits
    HRESET = 1'b1;
    tick();
    checkOutput("reset_again", 3'b001, 2'd0, 2'd0);
    HRESET = 1'b0;
    applyStimulus(3'b101, {2'd3, 2'd0, 2'd0}, 3'b110, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("lock_hold", 3'b001, 2'd0, 2'd0);
    end
    applyStimulus(3'b101, {2'd3, 2'd0, 2'd0}, 3'b111, 1'b1);
    tick();
    checkOutput("lock_release", 3'b100, 2'd2, 2'd0);

    // Wait states freeze everything even though m1 is the only requester
    applyStimulus(3'b010, {2'd3, 2'd1, 2'd0}, 3'b111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("wait_freeze", 3'b100, 2'd2, 2'd0);
    end
    slv_HREADY = 1'b1;
    tick();
    checkOutput("wait_switch", 3'b010, 2'd1, 2'd2);
    tick();
    checkOutput("wait_data_follow", 3'b010, 2'd1, 2'd1);

    // Parking: no requests keep the last owner
    applyStimulus(3'b000, {2'd3, 2'd1, 2'd0}, 3'b111, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("park", 3'b010, 2'd1, 2'd1);
    end

    // Non-requesters never win, even with higher priority
    applyStimulus(3'b001, {2'd3, 2'd3, 2'd0}, 3'b111, 1'b1);
    tick();
    checkOutput("nonreq_c1", 3'b001, 2'd0, 2'd1);
    tick();
    checkOutput("nonreq_c2", 3'b001, 2'd0, 2'd0);

    // Equal-priority tie among all three masters
    HRESET = 1'b1;
    tick();
    checkOutput("tie_reset", 3'b001, 2'd0, 2'd0);
    HRESET = 1'b0;
    applyStimulus(3'b111, {2'd1, 2'd1, 2'd1}, 3'b111, 1'b1);
`ifdef AHB3LITE_ARB_ROUND_ROBIN_EN
    tick();
    checkOutput("tie_rr_1", 3'b010, 2'd1, 2'd0);
    tick();
    checkOutput("tie_rr_2", 3'b100, 2'd2, 2'd1);
    tick();
    checkOutput("tie_rr_3", 3'b001, 2'd0, 2'd2);
    tick();
    checkOutput("tie_rr_4", 3'b010, 2'd1, 2'd0);
`else
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("tie_fixed", 3'b001, 2'd0, 2'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb3lite_interconnect_slave_arbiter.md
# ahb3lite_interconnect_slave_arbiter

Per-slave-port arbiter for the AHB3-Lite multi-layer interconnect. Collects connection requests (HSEL), priorities and can_switch indications from every master port that can address this slave and returns a registered one-hot master_granted vector to those master ports. Also provides address-phase and data-phase master indices that drive the slave-port multiplexers. Switching happens only at transfer boundaries that the current owner declares safe and the slave accepts.

## Interface
- MASTERS, 3, number of master ports competing for this slave (≥1)
- MASTER_BITS, max(1,$clog2(MASTERS)), width of priority and index fields (localparam)
- HCLK  in  1  clock, rising edge
- HRESET  in  1  synchronous, active-high reset
- mst_HSEL  in  MASTERS  per-master request for this slave (slvHSEL bit from each master port)
- mst_priority  in  MASTERS×MASTER_BITS  packed per-master priority; numerically larger wins
- mst_can_switch  in  MASTERS  per-master "ownership may move after this cycle"
- slv_HREADY  in  1  slave HREADYOUT
- master_granted  out  MASTERS  registered one-hot grant
- master_sel  out  MASTER_BITS  index of granted master (address-phase mux select)
- data_master_sel  out  MASTER_BITS  index of master owning current data phase (HWDATA mux select)

## Operation
- Owner = master_sel; master_granted is always onehot(master_sel), never zero, never multi-hot.
- switch_ok = slv_HREADY & (~mst_HSEL[owner] | mst_can_switch[owner]).
- switch_ok=0: grant holds unconditionally, including locked sequences and undefined-length INCR bursts.
- switch_ok=1, no mst_HSEL bit set: grant holds (bus parked on last owner).
- switch_ok=1, ≥1 request: winner = requester with maximum mst_priority; ties resolved per Configuration. Winner registered into master_sel/master_granted.
- Non-requesting masters are never granted while any requester exists, regardless of priority.
- Owner keeps grant if it is the unique highest-priority requester.
- Round-robin pointer (when compiled in) = last winner index; updated only on a switch_ok cycle with ≥1 request.
- data_master_sel <= master_sel on every cycle with slv_HREADY=1; holds otherwise (data phase extended by wait states).
- Reset: master_granted=1 (master 0), master_sel=0, data_master_sel=0, RR pointer=0. Reset mid-burst abandons ownership immediately; no memory of prior state.
- MASTERS=1: all outputs constant at reset values; requests ignored.
- Priority of a requester is sampled only in the arbitration cycle; changes while not switching have no effect.

## Timing
- Grant latency: request in cycle n with switch_ok=1 -> master_granted valid cycle n+1.
- Owner switch visible on master_granted one cycle after the switch_ok cycle; master ports see a grant one cycle after their request at best (they hold the transfer in ACCESS_PENDING meanwhile).
- data_master_sel lags master_sel by exactly one HREADY-qualified cycle.
- No combinational path from any input to master_granted, master_sel or data_master_sel.
- Wait states (slv_HREADY=0) freeze all state.

## Configuration
- AHB3LITE_ARB_ROUND_ROBIN_EN defined: equal-priority tie goes to first requester found scanning indices pointer+1, pointer+2, … wrapping modulo MASTERS (pointer itself checked last).
- Not defined: equal-priority tie goes to lowest requesting index; no pointer register.

## Test plan
- Reset: assert HRESET 2 cycles with mst_HSEL=3'b111 -> master_granted=3'b001, master_sel=0, data_master_sel=0 throughout and first cycle after.
- Priority: mst_HSEL=3'b110, priorities {m2=2,m1=1}, can_switch all 1, HREADY=1 -> next cycle master_granted=3'b100, master_sel=2.
- Lock/burst hold: owner m0 requesting with mst_can_switch[0]=0 for 4 cycles while m2 (prio 3) requests -> grant stays 3'b001; cycle after can_switch[0]=1 -> 3'b100.
- Wait state: switch conditions met but slv_HREADY=0 for 3 cycles -> master_granted and data_master_sel unchanged; first HREADY=1 cycle switches, data_master_sel follows one cycle later.
- Tie, RR_EN defined: all three request, equal priority, can_switch=1 each cycle -> grant sequence 3'b010,3'b100,3'b001,3'b010; without macro -> constant 3'b001.
- Parking: all mst_HSEL drop after m1 owns -> master_granted stays 3'b010 indefinitely.
